// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide opcodes and latency constants for the MIPS datapath
package mips_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;
    localparam int MD_CYCLES  = 32;
    localparam int MD_LATENCY = 34;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request and HI/LO result bundle for the multiply/divide unit
interface muldiv_unit_if import mips_pkg::*; #(parameter int WIDTH = 32);
    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, rs_data, rt_data, mthi, mtlo, wdata, input busy, done, hi, lo);
    modport slave (input start, op, rs_data, rt_data, mthi, mtlo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate for operand magnitudes and result sign correction
module md_sign_fix #(parameter int W = 32) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers, fixed 34-cycle latency
module muldiv_unit
    import mips_pkg::*;
#(parameter int WIDTH = 32) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} md_state_t;
    localparam int CW = $clog2(MD_CYCLES);
    md_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
    logic [WIDTH-1:0] rs_mag, rt_mag, quo_fix, rem_fix;
    logic [WIDTH:0] sum, trial, diff;
    logic is_div, is_signed, sgn_rs, sgn_rt, div0, ge;
    assign is_div    = bus.op inside {MD_DIV, MD_DIVU};
    assign is_signed = bus.op inside {MD_MULT, MD_DIV};
    assign sgn_rs    = is_signed & bus.rs_data[WIDTH-1];
    assign sgn_rt    = is_signed & bus.rt_data[WIDTH-1];
    md_sign_fix #(WIDTH)   u_rs   (.val(bus.rs_data), .neg(sgn_rs), .res(rs_mag));
    md_sign_fix #(WIDTH)   u_rt   (.val(bus.rt_data), .neg(sgn_rt), .res(rt_mag));
    md_sign_fix #(2*WIDTH) u_prod (.val(acc_q), .neg(neg_q), .res(prod_fix));
    md_sign_fix #(WIDTH)   u_quo  (.val(acc_q[WIDTH-1:0]), .neg(neg_q), .res(quo_fix));
    md_sign_fix #(WIDTH)   u_rem  (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(rneg_q), .res(rem_fix));
    assign div0  = b_q == '0;
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff  = trial - {1'b0, b_q};
    // partial remainder stays below the divisor, so the borrow bit alone decides each quotient bit
    assign ge    = ~diff[WIDTH] | div0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == S_IDLE && bus.start) begin
            state_d = S_CALC;
            cnt_d   = '0;
            div_d   = is_div;
            neg_d   = sgn_rs ^ sgn_rt;
            rneg_d  = sgn_rs;
            b_d     = is_div ? rt_mag : rs_mag;
            acc_d   = {{WIDTH{1'b0}}, is_div ? rs_mag : rt_mag};
        end else if (state_q == S_IDLE) begin
            hi_d = bus.mthi ? bus.wdata : hi_q;
            lo_d = bus.mtlo ? bus.wdata : lo_q;
        end else if (state_q == S_CALC) begin
            cnt_d   = cnt_q + 1'b1;
            acc_d   = div_q ? {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                            : {sum, acc_q[WIDTH-1:1]};
            state_d = (cnt_q == CW'(MD_CYCLES - 1)) ? S_FIX : S_CALC;
        end else begin
            state_d = S_IDLE;
            hi_d    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? (div0 ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
        end
        busy_d = state_d != S_IDLE;
        done_d = state_q == S_FIX;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a cycle-level arithmetic model
module tb_muldiv_unit;
    import mips_pkg::*;
    logic clk, rst_n;
    int checks = 0;
    int errors = 0;
    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend = '0;
    int          left = 0;
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (op[1] && b == 0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            default: p = {a % b, a / b};
        endcase
        return p;
    endfunction
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            left   <= 0;
        end else if (left == 0) begin
            if (bus.start) begin
                pend   <= ref_res(bus.op, bus.rs_data, bus.rt_data);
                left   <= MD_LATENCY - 1;
                m_busy <= 1'b1;
            end else begin
                if (bus.mthi) m_hi <= bus.wdata;
                if (bus.mtlo) m_lo <= bus.wdata;
            end
        end else begin
            left <= left - 1;
            if (left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= pend[63:32];
                m_lo   <= pend[31:0];
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("done", 64'(bus.done), 64'(m_done));
        chk("hi", 64'(bus.hi), 64'(m_hi));
        chk("lo", 64'(bus.lo), 64'(m_lo));
    endtask
    task automatic run(input string name, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit poke);
        int k;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        tick();
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 40) begin
            if (poke && k == 5) begin
                bus.start   = 1'b1;
                bus.op      = MD_DIVU;
                bus.rs_data = 32'd9;
                bus.rt_data = 32'd3;
                bus.mthi    = 1'b1;
                bus.wdata   = 32'hDEAD_BEEF;
            end
            tick();
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            k++;
        end
        chk({name, "_latency"}, 64'(k), 64'd34);
        chk({name, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({name, "_lo"}, 64'(bus.lo), 64'(el));
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction
    initial begin
        bit saw_done;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = MD_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        run("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("mult_m1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234;
        tick();
        bus.mtlo = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h1234);
        chk("mtlo_hi", 64'(bus.hi), 64'd5);
        chk("mtlo_done", 64'(bus.done), 64'd0);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hABCD;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mtboth_hi", 64'(bus.hi), 64'hABCD);
        chk("mtboth_lo", 64'(bus.lo), 64'hABCD);
        run("busy_poke", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
        bus.start   = 1'b1;
        bus.op      = MD_MULTU;
        bus.rs_data = 32'h1234_5678;
        bus.rt_data = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done |= bus.done;
        end
        chk("midrst_nodone", 64'(saw_done), 64'd0);
        run("after_rst", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            bus.start   = $urandom_range(0, 5) == 0;
            bus.op      = md_op_t'($urandom_range(0, 3));
            bus.rs_data = pick();
            bus.rt_data = pick();
            bus.mthi    = $urandom_range(0, 7) == 0;
            bus.mtlo    = $urandom_range(0, 7) == 0;
            bus.wdata   = $urandom();
            tick();
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU from the execute stage, computes over a fixed 34-cycle latency, and holds the result in HI/LO. The writeback-select 2:1 mux consumes `hi`/`lo` on its data1 input for MFHI/MFLO. `busy` stalls the pipeline while an operation is in flight.

## Interface

- `WIDTH`, 32: operand and HI/LO width. Only 32 is verified.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: launch the operation in `op`. Honoured only in IDLE.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32: multiplicand or dividend.
- `rt_data`  in  32: multiplier or divisor.
- `mthi`  in  1: write `wdata` to HI. Honoured only in IDLE with `start` low.
- `mtlo`  in  1: write `wdata` to LO, under the same rule as `mthi`.
- `wdata`  in  32: data for MTHI/MTLO.
- `busy`  out  1: high while in CALC or FIX.
- `done`  out  1: one-cycle pulse in the first cycle in which new HI/LO values are visible.
- `hi`  out  32: HI register, driven directly from the register.
- `lo`  out  32: LO register, driven directly from the register.

## Operation

- **FSM states:** IDLE, CALC, FIX.
  - IDLE → CALC on `start`. Operands, `op` and signs are latched and the counter is cleared.
  - CALC → FIX when the counter reaches 31, giving 32 CALC cycles.
  - FIX → IDLE unconditionally.
- **Signed ops (MULT, DIV):** operands are converted to magnitudes on capture. The core always runs unsigned. FIX applies sign correction and then writes HI/LO.
- **Multiply:** radix-2 shift-add, one multiplier bit per cycle, into a 64-bit accumulator. Product sign is `rs[31]^rt[31]`. HI = product[63:32], LO = product[31:0].
- **Divide:** restoring division, one quotient bit per cycle, using a 33-bit partial remainder. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- **Divide by zero:** LO = 0xFFFFFFFF, HI = `rs_data` as captured. This applies to both DIV and DIVU, and the full latency is still taken.
- **DIV 0x80000000 / -1:** LO = 0x80000000, HI = 0. This result follows naturally from magnitude arithmetic.
- **`start` while busy:** ignored, with no queueing. The requester holds the stall until `busy` falls.
- **`mthi`/`mtlo` while busy, or in the same cycle as `start`:** dropped, and `start` wins. `mthi` and `mtlo` together in IDLE write `wdata` to both registers.
- **HI/LO update rules:** HI/LO change only on a FIX-exit edge or an honoured MTHI/MTLO. Outputs are stable for the whole of CALC.
- **Reset:** when `rst_n` is low at an edge, the unit goes to IDLE and clears HI, LO, accumulator and counter. `busy` and `done` go to 0. This applies mid-operation too, and the in-flight op is discarded.

## Timing

- **Launch:** `start` sampled high in IDLE at the end of cycle N.
  - `busy` is high in cycles N+1 to N+33: 32 CALC cycles plus 1 FIX cycle.
  - In cycle N+34, `done` is 1, `busy` is 0, and `hi`/`lo` carry the result.
- **Back-to-back:** a new `start` can be accepted in cycle N+34, the same cycle as `done`.
- **MTHI/MTLO:** asserted in cycle M, the new value is visible in cycle M+1. `done` stays 0.
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure

- **Shared package `mips_pkg`:**
  - `md_op_t` enum, with the MULT, MULTU, DIV and DIVU encodings above. The decoder uses the same encodings.
  - `MD_CYCLES` = 32 and `MD_LATENCY` = 34, which the hazard unit needs for stall accounting.
- **Local to this module:** the `md_state_t` FSM enum.
- **Sub-module:** one natural sub-module, `md_sign_fix`. It is a combinational magnitude/negate helper used on capture and in FIX. Everything else is in `muldiv_unit`.

## Test plan

- MULT 7 × 0xFFFFFFFD (−3), start in cycle 0 → `done` in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high for cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT of the same operands → HI=0, LO=1.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5, still after 34 cycles.
- MTLO 0x1234 in IDLE → `lo`=0x1234 next cycle, `hi` unchanged. MTHI and a second `start` during `busy` → both ignored; HI/LO equal the original op's result.
- `rst_n` low in cycle 10 of a MULTU → next cycle `busy`=0, `hi`=`lo`=0; `done` never pulses; a fresh `start` is then accepted normally.
